ahb_bus_arbiter: RTL

//   Shares one AHB-Lite slave-side bus among NUM_MASTERS ahb_master instances.
//   - Round-robin grant via hbusreq/hgrant.
//   - Muxes address/control by address-phase owner, hwdata by data-phase owner.
//   - Holds ownership across fixed-length bursts, INCR bursts and locked sequences.
//   - Sits between the master instances and the slave decoder/mux.

---
 rtl/ahb_pkg.sv | 36 +++
 rtl/ahb_rr_pick.sv | 34 +++
 rtl/ahb_bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings, burst length decode and arbiter FSM states.
// Shared by the bus arbiter and its round-robin picker.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_BURST = 2'd1,
      ST_HOLD  = 2'd2
   } arb_state_t;

   // Beats in a fixed-length burst; 0 marks the open-ended INCR burst.
   function automatic logic [4:0] burst_len(input logic [2:0] hburst);
      case (hburst)
         HBURST_SINGLE:               burst_len = 5'd1;
         HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
         default:                     burst_len = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester after ptr wins.
// No requester -> one-hot grant to master 0 with hit=0.
module ahb_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          hit
);

   logic [IW-1:0] j;

   always_comb begin
      gnt = '0;
      idx = '0;
      hit = 1'b0;
      j   = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + 1 + k) % N);
         if (!hit && req[j]) begin
            hit    = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
      if (!hit) begin
         gnt[0] = 1'b1;
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite bus arbiter: round-robin grant, ownership pipeline, burst/lock hold.
// Grant->address owner and address->data owner each take one hready edge; hready=0 freezes all.
module ahb_bus_arbiter
   import ahb_pkg::*;
#(
   parameter  int NUM_MASTERS = 4,
   parameter  int AW          = 32,
   parameter  int DW          = 32,
   localparam int IW          = $clog2(NUM_MASTERS)
) (
   input  logic                      hclk,
   input  logic                      hresetn,
   input  logic [NUM_MASTERS-1:0]    hbusreq,
   input  logic [NUM_MASTERS-1:0]    hlock,
   input  logic [NUM_MASTERS*AW-1:0] haddr_m,
   input  logic [NUM_MASTERS*2-1:0]  htrans_m,
   input  logic [NUM_MASTERS-1:0]    hwrite_m,
   input  logic [NUM_MASTERS*3-1:0]  hsize_m,
   input  logic [NUM_MASTERS*3-1:0]  hburst_m,
   input  logic [NUM_MASTERS*DW-1:0] hwdata_m,
   input  logic                      hready,
   input  logic                      hresp,
   output logic [NUM_MASTERS-1:0]    hgrant,
   output logic [IW-1:0]             hmaster,
   output logic                      hmastlock,
   output logic [AW-1:0]             haddr,
   output logic [1:0]                htrans,
   output logic                      hwrite,
   output logic [2:0]                hsize,
   output logic [2:0]                hburst,
   output logic [DW-1:0]             hwdata
);

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IW-1:0]          pick_idx;
   logic                   pick_hit;
   logic [IW-1:0]          gnt_idx;
   logic [IW-1:0]          rr_ptr;
   logic [IW-1:0]          hmaster_d;
   arb_state_t             state;
   arb_state_t             state_next;
   logic [4:0]             rem;
   logic [4:0]             rem_next;
   logic                   allow;

   ahb_rr_pick #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_pick (
      .req (hbusreq),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .hit (pick_hit)
   );

   assign haddr  = haddr_m[int'(hmaster)*AW +: AW];
   assign htrans = htrans_m[int'(hmaster)*2 +: 2];
   assign hwrite = hwrite_m[hmaster];
   assign hsize  = hsize_m[int'(hmaster)*3 +: 3];
   assign hburst = hburst_m[int'(hmaster)*3 +: 3];
   assign hwdata = hwdata_m[int'(hmaster_d)*DW +: DW];

   // allow says whether hgrant may be re-evaluated at this hready edge.
   always_comb begin
      state_next = state;
      rem_next   = rem;
      allow      = 1'b0;
      case (state)
         ST_ARB: begin
            allow = 1'b1;
            if (htrans == HTRANS_NONSEQ) begin
               if (hmastlock || hburst == HBURST_INCR) begin
                  state_next = ST_HOLD;
                  allow      = 1'b0;
               end else if (hburst != HBURST_SINGLE) begin
                  rem_next   = burst_len(hburst) - 5'd1;
                  state_next = ST_BURST;
                  allow      = 1'b0;
               end
            end
         end
         ST_BURST: begin
            if (rem == 5'd0) begin
               state_next = ST_ARB;
               allow      = 1'b1;
            end else if (htrans == HTRANS_SEQ) begin
               // Releasing one beat early lets the new owner's address phase follow the last beat.
               rem_next = rem - 5'd1;
               allow    = (rem_next <= 5'd1);
               if (rem_next == 5'd0) begin
                  state_next = ST_ARB;
               end
            end
         end
         ST_HOLD: begin
            if (!hbusreq[hmaster] && !hlock[hmaster]) begin
               state_next = ST_ARB;
               allow      = 1'b1;
            end
         end
         default: begin
            state_next = ST_ARB;
            rem_next   = 5'd0;
         end
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         hgrant    <= NUM_MASTERS'(1);
         gnt_idx   <= '0;
         rr_ptr    <= '0;
         hmaster   <= '0;
         hmaster_d <= '0;
         hmastlock <= 1'b0;
         state     <= ST_ARB;
         rem       <= 5'd0;
      end else if (hresp && !hready) begin
         // ERROR first cycle: abandon the burst so the next hready edge can rearbitrate.
         state <= ST_ARB;
         rem   <= 5'd0;
      end else if (hready) begin
         state     <= state_next;
         rem       <= rem_next;
         hmaster   <= gnt_idx;
         hmaster_d <= hmaster;
         hmastlock <= hlock[gnt_idx];
         if (allow) begin
            hgrant  <= pick_gnt;
            gnt_idx <= pick_idx;
            if (pick_hit) begin
               rr_ptr <= pick_idx;
            end
         end
      end
   end

endmodule
